filter_scheduler: RTL and testbench

Sequencer that time-multiplexes one external ADC across CHANNELS analog inputs. It feeds each converted sample into that channel's dedicated moving-average filter instance through the filter's enable/finish handshake, and publishes the filtered results with per-channel warm-up flags. It sits between the ADC interface and the bank of moving-average filters and provides the periodic sample timebase for the actuator control loop.

---
 rtl/filter_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_filter_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_scheduler.sv
// filter_scheduler: sweeps one ADC across all channels, feeds each
// sample to its moving-average filter and latches the filtered result.
module filter_scheduler #(
    parameter int CHANNELS          = 4,
    parameter int SIGNAL_RESOLUTION = 12,
    parameter int NUMBER_POINTS     = 32,
    parameter int SAMPLE_PERIOD     = 1000,
    parameter int SETTLE_CYCLES     = 8,
    parameter int TIMEOUT           = 15,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  nReset_i,
    input  logic                                  run_i,
    input  logic                                  clear_i,
    input  logic [SIGNAL_RESOLUTION-1:0]          adc_data_i,
    input  logic                                  adc_valid_i,
    output logic                                  adc_start_o,
    output logic [CW-1:0]                         channel_o,
    output logic [CHANNELS-1:0]                   filt_enable_o,
    output logic [SIGNAL_RESOLUTION-1:0]          filt_signal_o,
    input  logic [CHANNELS-1:0]                   filt_finish_i,
    input  logic [CHANNELS*SIGNAL_RESOLUTION-1:0] filt_data_i,
    output logic [CHANNELS*SIGNAL_RESOLUTION-1:0] result_o,
    output logic [CHANNELS-1:0]                   result_valid_o,
    output logic                                  update_o,
    output logic [2:0]                            error_o
);

    localparam int SR   = SIGNAL_RESOLUTION;
    localparam int TW   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int WMAX = (SETTLE_CYCLES > TIMEOUT) ? SETTLE_CYCLES : TIMEOUT;
    localparam int WW   = $clog2(WMAX + 1);
    localparam int NW   = $clog2(NUMBER_POINTS + 1);

    localparam logic [TW-1:0]       TICK_LAST   = TW'(SAMPLE_PERIOD - 1);
    localparam logic [WW-1:0]       SETTLE_LAST = WW'(SETTLE_CYCLES - 1);
    localparam logic [WW-1:0]       WAIT_LAST   = WW'(TIMEOUT - 1);
    localparam logic [NW-1:0]       WARM_FULL   = NW'(NUMBER_POINTS);
    localparam logic [CW-1:0]       CH_LAST     = CW'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0] EN_ONE      = CHANNELS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_CONVERT,
        S_FEED,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_STORE
    } state_t;

    state_t        state;
    logic [CW-1:0] ch;
    logic [WW-1:0] wcnt;
    logic [TW-1:0] tcnt;

    logic [SR-1:0] res_q    [CHANNELS];
    logic [NW-1:0] warm_q   [CHANNELS];
    logic [SR-1:0] fdata_arr[CHANNELS];

    logic tick;
    logic fin_ch;
    logic wait_over;
    logic last_ch;
    logic ev_adc_to;
    logic ev_filt_to;
    logic ev_overrun;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign fdata_arr[g]           = filt_data_i[g*SR +: SR];
        assign result_o[g*SR +: SR]   = res_q[g];
        assign result_valid_o[g]      = (warm_q[g] == WARM_FULL);
    end

    assign channel_o  = ch;
    assign tick       = run_i && (tcnt == TICK_LAST);
    assign fin_ch     = filt_finish_i[ch];
    assign wait_over  = (wcnt == WAIT_LAST);
    assign last_ch    = (ch == CH_LAST);

    // A wait state gives up when its counter has spanned TIMEOUT cycles
    assign ev_adc_to  = (state == S_CONVERT) && !adc_valid_i && wait_over;
    assign ev_filt_to = wait_over &&
                        (((state == S_WAIT_BUSY) && fin_ch) ||
                         ((state == S_WAIT_DONE) && !fin_ch));
    assign ev_overrun = tick && (state != S_IDLE);

    // Sweep timebase: free-runs while enabled, parked at zero otherwise
    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            tcnt <= '0;
        end else if (!run_i || (tcnt == TICK_LAST)) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Sticky error flags; a new event beats a simultaneous clear
    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            error_o <= '0;
        end else begin
            error_o <= (clear_i ? 3'b000 : error_o) |
                       {ev_overrun, ev_filt_to, ev_adc_to};
        end
    end

    // Per-channel sequencer: select, convert, feed filter, collect result
    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            state         <= S_IDLE;
            ch            <= '0;
            wcnt          <= '0;
            adc_start_o   <= 1'b0;
            filt_enable_o <= '0;
            filt_signal_o <= '0;
            update_o      <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                res_q[i]  <= '0;
                warm_q[i] <= '0;
            end
        end else begin
            adc_start_o   <= 1'b0;
            filt_enable_o <= '0;
            update_o      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        ch    <= '0;
                        wcnt  <= '0;
                        state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (wcnt == SETTLE_LAST) begin
                        wcnt        <= '0;
                        adc_start_o <= 1'b1;
                        state       <= S_CONVERT;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_CONVERT: begin
                    if (adc_valid_i) begin
                        filt_signal_o <= adc_data_i;
                        filt_enable_o <= EN_ONE << ch;
                        state         <= S_FEED;
                    end else if (ev_adc_to) begin
                        update_o <= last_ch;
                        state    <= S_STORE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_FEED: begin
                    wcnt  <= '0;
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!fin_ch) begin
                        wcnt  <= '0;
                        state <= S_WAIT_DONE;
                    end else if (ev_filt_to) begin
                        update_o <= last_ch;
                        state    <= S_STORE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (fin_ch) begin
                        res_q[ch] <= fdata_arr[ch];
                        if (warm_q[ch] != WARM_FULL) begin
                            warm_q[ch] <= warm_q[ch] + 1'b1;
                        end
                        update_o <= last_ch;
                        state    <= S_STORE;
                    end else if (ev_filt_to) begin
                        update_o <= last_ch;
                        state    <= S_STORE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_STORE: begin
                    if (last_ch) begin
                        state <= S_IDLE;
                    end else begin
                        ch    <= ch + 1'b1;
                        wcnt  <= '0;
                        state <= S_SELECT;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_scheduler.sv
// tb_filter_scheduler: ADC and filter models around filter_scheduler,
// table-driven sweeps plus randomized sweeps against a sweep-level model.
module tb_filter_scheduler;

    localparam int CH  = 4;
    localparam int SR  = 12;
    localparam int NP  = 32;
    localparam int SP  = 100;
    localparam int SET = 8;
    localparam int TO  = 15;

    logic              clk_i = 1'b0;
    logic              nReset_i = 1'b0;
    logic              run_i = 1'b0;
    logic              clear_i = 1'b0;
    logic [SR-1:0]     adc_data_i;
    logic              adc_valid_i;
    logic              adc_start_o;
    logic [1:0]        channel_o;
    logic [CH-1:0]     filt_enable_o;
    logic [SR-1:0]     filt_signal_o;
    logic [CH-1:0]     filt_finish_i;
    logic [CH*SR-1:0]  filt_data_i;
    logic [CH*SR-1:0]  result_o;
    logic [CH-1:0]     result_valid_o;
    logic              update_o;
    logic [2:0]        error_o;

    filter_scheduler #(
        .CHANNELS(CH),
        .SIGNAL_RESOLUTION(SR),
        .NUMBER_POINTS(NP),
        .SAMPLE_PERIOD(SP),
        .SETTLE_CYCLES(SET),
        .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i),
        .nReset_i(nReset_i),
        .run_i(run_i),
        .clear_i(clear_i),
        .adc_data_i(adc_data_i),
        .adc_valid_i(adc_valid_i),
        .adc_start_o(adc_start_o),
        .channel_o(channel_o),
        .filt_enable_o(filt_enable_o),
        .filt_signal_o(filt_signal_o),
        .filt_finish_i(filt_finish_i),
        .filt_data_i(filt_data_i),
        .result_o(result_o),
        .result_valid_o(result_valid_o),
        .update_o(update_o),
        .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct { int cyc; int ch; } st_ev_t;
    typedef struct { int cyc; logic [CH-1:0] en; logic [SR-1:0] sig; } en_ev_t;
    typedef struct {
        int cyc; logic [CH*SR-1:0] res; logic [CH-1:0] vld; logic [2:0] err;
    } up_ev_t;
    typedef struct { int lat; int blk; int stk; int len; logic [2:0] err; } vec_t;

    st_ev_t start_q[$];
    en_ev_t en_q[$];
    up_ev_t upd_q[$];

    // environment knobs
    int lat = 2;
    int blk = -1;
    int stk = -1;
    logic [SR-1:0] adc_val[CH];

    // reference model state
    logic [SR-1:0] mres[CH];
    int            mwarm[CH];

    int checks = 0;
    int failures = 0;

    function automatic logic [SR-1:0] fmodel(input int k, input logic [SR-1:0] s);
        logic [SR-1:0] b;
        b = SR'((k + 1) * 256);
        return s ^ b;
    endfunction

    function automatic int model_len(input int l, input int b, input int st);
        int n;
        n = 0;
        for (int k = 0; k < CH; k++) begin
            if (k == b) n += SET + TO + 1;
            else if (k == st) n += SET + l + TO + 3;
            else n += SET + l + 6;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ADC and filter models plus event logging
    int adc_due = -1;
    int adc_ch = 0;
    int en_cyc[CH] = '{-100, -100, -100, -100};
    logic [SR-1:0] fdata[CH] = '{0, 0, 0, 0};

    always @(negedge clk_i) begin
        if (adc_start_o) begin
            adc_due = cyc + lat;
            adc_ch = int'(channel_o);
            start_q.push_back('{cyc, int'(channel_o)});
        end
        adc_valid_i = (cyc == adc_due) && (adc_ch != blk);
        adc_data_i = adc_val[adc_ch];
        for (int k = 0; k < CH; k++) begin
            if (filt_enable_o[k]) begin
                en_cyc[k] = cyc;
                fdata[k] = fmodel(k, filt_signal_o);
            end
            filt_finish_i[k] = (k == stk) || !(cyc > en_cyc[k] && cyc < en_cyc[k] + 3);
            filt_data_i[k*SR +: SR] = fdata[k];
        end
        if (filt_enable_o != '0) en_q.push_back('{cyc, filt_enable_o, filt_signal_o});
        if (update_o) upd_q.push_back('{cyc, result_o, result_valid_o, error_o});
    end

    task automatic clear_logs();
        start_q.delete();
        en_q.delete();
        upd_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " adc_start"}, adc_start_o, 0);
        chk({tag, " channel"}, channel_o, 0);
        chk({tag, " enable"}, filt_enable_o, 0);
        chk({tag, " signal"}, filt_signal_o, 0);
        chk({tag, " result"}, result_o, 0);
        chk({tag, " valid"}, result_valid_o, 0);
        chk({tag, " update"}, update_o, 0);
        chk({tag, " error"}, error_o, 0);
    endtask

    // One sweep starting at cycle s: check events against the model
    task automatic do_sweep(input int s, input int exp_len, input logic [2:0] exp_err,
                            input string tag);
        int off;
        int ei;
        logic [CH*SR-1:0] eres;
        logic [CH-1:0] evld;
        off = 0;
        ei = 0;
        while (cyc < s + exp_len + 2) @(negedge clk_i);
        chk({tag, " start count"}, start_q.size(), CH);
        for (int k = 0; k < CH; k++) begin
            int t0;
            t0 = s + off + SET;
            if (k < start_q.size()) begin
                chk({tag, " start cycle"}, start_q[k].cyc, t0);
                chk({tag, " start channel"}, start_q[k].ch, k);
            end
            if (k != blk) begin
                if (ei < en_q.size()) begin
                    chk({tag, " enable cycle"}, en_q[ei].cyc, t0 + lat + 1);
                    chk({tag, " enable onehot"}, en_q[ei].en, 1 << k);
                    chk({tag, " filt_signal"}, en_q[ei].sig, adc_val[k]);
                end
                ei++;
            end
            if (k != blk && k != stk) begin
                mres[k] = fmodel(k, adc_val[k]);
                if (mwarm[k] < NP) mwarm[k]++;
            end
            off += (k == blk) ? SET + TO + 1 : (k == stk) ? SET + lat + TO + 3 : SET + lat + 6;
        end
        chk({tag, " enable count"}, en_q.size(), ei);
        for (int k = 0; k < CH; k++) begin
            eres[k*SR +: SR] = mres[k];
            evld[k] = (mwarm[k] == NP);
        end
        chk({tag, " update count"}, upd_q.size(), 1);
        if (upd_q.size() > 0) begin
            chk({tag, " update cycle"}, upd_q[0].cyc, s + exp_len - 1);
            chk({tag, " result"}, upd_q[0].res, eres);
            chk({tag, " result_valid"}, upd_q[0].vld, evld);
            chk({tag, " error"}, upd_q[0].err, exp_err);
        end
        clear_logs();
        @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk({tag, " error cleared"}, error_o, 0);
    endtask

    vec_t rows[8];

    initial begin
        int s;
        int w;
        rows[0] = '{2, -1, -1, 64, 3'b000};
        rows[1] = '{1, -1, -1, 60, 3'b000};
        rows[2] = '{2, 2, -1, 72, 3'b001};
        rows[3] = '{2, -1, 1, 76, 3'b010};
        rows[4] = '{5, -1, -1, 76, 3'b000};
        rows[5] = '{12, -1, -1, 104, 3'b100};
        rows[6] = '{3, 0, -1, 75, 3'b001};
        rows[7] = '{2, -1, 3, 76, 3'b010};
        for (int k = 0; k < CH; k++) begin
            adc_val[k] = '0;
            mres[k] = '0;
            mwarm[k] = 0;
        end

        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        nReset_i = 1'b1;
        run_i = 1'b1;
        s = cyc + SP;

        for (int i = 0; i < 8; i++) begin
            lat = rows[i].lat;
            blk = rows[i].blk;
            stk = rows[i].stk;
            for (int k = 0; k < CH; k++) adc_val[k] = (i == 0) ? '0 : SR'($urandom);
            do_sweep(s, rows[i].len, rows[i].err, $sformatf("vec%0d", i));
            if (i == 0) chk("nominal result", result_o, 48'h400300200100);
            s = s + SP * (1 + rows[i].len / SP);
        end

        // asynchronous reset in the middle of channel 2's conversion
        lat = 3;
        blk = -1;
        stk = -1;
        for (int k = 0; k < CH; k++) adc_val[k] = SR'($urandom);
        w = 0;
        while (!(adc_start_o && channel_o == 2'd2) && w < 2 * SP + 100) begin
            @(negedge clk_i);
            w++;
        end
        chk("reach ch2 convert", adc_start_o && channel_o == 2'd2, 1);
        @(negedge clk_i);
        nReset_i = 1'b0;
        #1;
        check_reset_outputs("async reset");
        for (int k = 0; k < CH; k++) begin
            mres[k] = '0;
            mwarm[k] = 0;
        end
        repeat (2) @(negedge clk_i);
        clear_logs();
        nReset_i = 1'b1;
        s = cyc + SP;
        @(negedge clk_i);
        chk("no enable after release", filt_enable_o, 0);

        // randomized sweeps, long enough to cross the warm-up threshold
        for (int n = 0; n < 48; n++) begin
            int r;
            int len;
            logic [2:0] e;
            lat = $urandom_range(1, 6);
            r = $urandom_range(0, 7);
            blk = -1;
            stk = -1;
            if (r == 0) blk = $urandom_range(0, CH - 1);
            else if (r == 1) stk = $urandom_range(0, CH - 1);
            for (int k = 0; k < CH; k++) adc_val[k] = SR'($urandom);
            len = model_len(lat, blk, stk);
            e = {len >= SP, stk >= 0, blk >= 0};
            do_sweep(s, len, e, $sformatf("rnd%0d", n));
            s = s + SP * (1 + len / SP);
        end

        // dropping run_i mid-sweep lets that sweep finish, then idles
        lat = 2;
        blk = -1;
        stk = -1;
        for (int k = 0; k < CH; k++) adc_val[k] = SR'($urandom);
        while (cyc < s + 10) @(negedge clk_i);
        run_i = 1'b0;
        do_sweep(s, 64, 3'b000, "stop");
        repeat (2 * SP + 20) @(negedge clk_i);
        chk("idle after stop", start_q.size(), 0);
        chk("no update after stop", upd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
